// File: rtl/fmac_round_pack_pkg.sv
// Shared constants, types and the rounding-decision helper for the FMAC output back end.
// Stage 1 writes a norm_t; stage 2 reads it to round and pack the result.
package fpu_defs_fmac;

  localparam int C_EXP           = 8;
  localparam int C_MANT          = 23;
  localparam int C_BIAS          = 127;
  localparam int C_RM            = 2;
  localparam int C_LEADONE_WIDTH = 7;

  localparam int C_PRE_EXP      = C_EXP + 2;
  localparam int C_MANT_PRENORM = C_MANT + 1;
  localparam int C_MANT_SUM     = 2 * C_MANT_PRENORM;
  localparam int C_SHIFT_SAT    = 26;

  localparam logic [C_EXP-1:0]  C_EXP_INF    = 8'hFF;
  localparam logic [C_MANT-1:0] C_MANT_NAN   = 23'h400000;
  localparam logic [31:0]       C_MAX_FINITE = 32'h7F7FFFFF;

  typedef enum logic [C_RM-1:0] {
    RM_NEAREST  = 2'd0,
    RM_TRUNC    = 2'd1,
    RM_PLUSINF  = 2'd2,
    RM_MINUSINF = 2'd3
  } rm_e;

  // Stage 1 result: exponent is non-negative here (0 marks a denormal/tiny value).
  typedef struct packed {
    logic                    sign;
    logic [C_PRE_EXP:0]      exp;
    logic [C_MANT_PRENORM-1:0] mant;
    logic                    guard;
    logic                    sticky;
    rm_e                     rm;
    logic                    nan;
    logic                    inf;
    logic                    invalid;
    logic                    zero;
  } norm_t;

  function automatic logic round_up(rm_e rm, logic sign, logic lsb, logic g, logic s);
    case (rm)
      RM_NEAREST: return g & (s | lsb);
      RM_TRUNC:   return 1'b0;
      RM_PLUSINF: return ~sign & (g | s);
      default:    return sign & (g | s);
    endcase
  endfunction

endpackage

// File: rtl/fmac_lzc.sv
// Leading-zero counter over the 48-bit FMAC sum; reports 48 and raises zero_o
// when the input is all zeros.
module fmac_lzc
  import fpu_defs_fmac::*;
(
  input  logic [C_MANT_SUM-1:0]      data_i,
  output logic [C_LEADONE_WIDTH-1:0] count_o,
  output logic                       zero_o
);

  // Scanning upward lets the most significant set bit win.
  always_comb begin
    count_o = C_LEADONE_WIDTH'(C_MANT_SUM);
    zero_o  = 1'b1;
    for (int i = 0; i < C_MANT_SUM; i++) begin
      if (data_i[i]) begin
        count_o = C_LEADONE_WIDTH'(C_MANT_SUM - 1 - i);
        zero_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fmac_round_pack.sv
// FMAC back end: normalize (stage 1) then round and pack to IEEE single with
// exception flags (stage 2), as a two-entry valid/ready pipeline.
module fmac_round_pack
  import fpu_defs_fmac::*;
(
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  Valid_SI,
  output logic                  Ready_SO,
  input  logic                  Sign_DI,
  input  logic [C_PRE_EXP-1:0]  Exp_DI,
  input  logic [C_MANT_SUM-1:0] Mant_DI,
  input  logic                  Sticky_SI,
  input  logic [C_RM-1:0]       RM_SI,
  input  logic                  NaN_SI,
  input  logic                  Inf_SI,
  input  logic                  Invalid_SI,
  output logic                  Valid_SO,
  input  logic                  Ready_SI,
  output logic [31:0]           Res_DO,
  output logic                  OF_SO,
  output logic                  UF_SO,
  output logic                  NX_SO,
  output logic                  NV_SO
);

  localparam int XW = C_PRE_EXP + 1;
  localparam int EW = C_PRE_EXP + 2;

  logic [C_LEADONE_WIDTH-1:0] lz_cnt;
  logic                       lz_zero;

  logic [EW-1:0]         exp_raw, shift_full;
  logic                  tiny_pre;
  logic [4:0]            shift_amt;
  logic [C_MANT_SUM-1:0] mant_norm, mant_fin, lost_mask;
  norm_t                 s1_calc;

  logic                    gs, up, ovf, ovf_to_inf;
  logic [C_MANT_PRENORM:0] mant_rnd;
  logic [XW-1:0]           exp_rnd;
  logic [C_MANT-1:0]       mant_out;
  logic [31:0]             res_calc;
  logic                    of_calc, uf_calc, nx_calc, nv_calc;

  logic        load1, load2;
  logic        v1_d, v1_q, v2_d, v2_q;
  norm_t       s1_d, s1_q;
  logic [31:0] res_d, res_q;
  logic        of_d, of_q, uf_d, uf_q, nx_d, nx_q, nv_d, nv_q;

  fmac_lzc u_lzc (
    .data_i  (Mant_DI),
    .count_o (lz_cnt),
    .zero_o  (lz_zero)
  );

  // Tiny results are denormalized by right-shifting; shifts beyond 26 only feed sticky.
  always_comb begin
    exp_raw    = {{2{Exp_DI[C_PRE_EXP-1]}}, Exp_DI} + EW'(1) - EW'(lz_cnt);
    tiny_pre   = exp_raw[EW-1] | (exp_raw == '0);
    shift_full = EW'(1) - exp_raw;
    shift_amt  = (shift_full > EW'(C_SHIFT_SAT)) ? 5'(C_SHIFT_SAT) : shift_full[4:0];
    mant_norm  = Mant_DI << lz_cnt;
    lost_mask  = ~({C_MANT_SUM{1'b1}} << shift_amt);
    mant_fin   = tiny_pre ? (mant_norm >> shift_amt) : mant_norm;

    s1_calc.sign    = Sign_DI;
    s1_calc.exp     = tiny_pre ? '0 : exp_raw[XW-1:0];
    s1_calc.mant    = mant_fin[C_MANT_SUM-1 -: C_MANT_PRENORM];
    s1_calc.guard   = mant_fin[C_MANT];
    s1_calc.sticky  = (|mant_fin[C_MANT-1:0]) | Sticky_SI |
                      (tiny_pre & (|(mant_norm & lost_mask)));
    s1_calc.rm      = rm_e'(RM_SI);
    s1_calc.nan     = NaN_SI;
    s1_calc.inf     = Inf_SI;
    s1_calc.invalid = Invalid_SI;
    s1_calc.zero    = lz_zero;
  end

  // A denormal that rounds up into bit 23 becomes the smallest normal.
  always_comb begin
    gs       = s1_q.guard | s1_q.sticky;
    up       = round_up(s1_q.rm, s1_q.sign, s1_q.mant[0], s1_q.guard, s1_q.sticky);
    mant_rnd = {1'b0, s1_q.mant} + {{C_MANT_PRENORM{1'b0}}, up};
    exp_rnd  = s1_q.exp;
    mant_out = mant_rnd[C_MANT-1:0];
    if (s1_q.exp != '0) begin
      if (mant_rnd[C_MANT_PRENORM]) begin
        exp_rnd  = s1_q.exp + XW'(1);
        mant_out = mant_rnd[C_MANT:1];
      end
    end else if (mant_rnd[C_MANT]) begin
      exp_rnd = XW'(1);
    end
    ovf        = exp_rnd >= XW'((1 << C_EXP) - 1);
    ovf_to_inf = (s1_q.rm == RM_NEAREST) ||
                 ((s1_q.rm == RM_PLUSINF) && !s1_q.sign) ||
                 ((s1_q.rm == RM_MINUSINF) && s1_q.sign);

    res_calc = {s1_q.sign, exp_rnd[C_EXP-1:0], mant_out};
    of_calc  = 1'b0;
    uf_calc  = (s1_q.exp == '0) & gs;
    nx_calc  = gs;
    nv_calc  = 1'b0;

    if (s1_q.nan) begin
      res_calc = {1'b0, C_EXP_INF, C_MANT_NAN};
      uf_calc  = 1'b0;
      nx_calc  = 1'b0;
      nv_calc  = s1_q.invalid;
    end else if (s1_q.inf) begin
      res_calc = {s1_q.sign, C_EXP_INF, {C_MANT{1'b0}}};
      uf_calc  = 1'b0;
      nx_calc  = 1'b0;
    end else if (s1_q.zero) begin
      res_calc = {s1_q.sign, {(C_EXP + C_MANT){1'b0}}};
      uf_calc  = 1'b0;
      nx_calc  = 1'b0;
    end else if (ovf) begin
      res_calc = ovf_to_inf ? {s1_q.sign, C_EXP_INF, {C_MANT{1'b0}}}
                            : (C_MAX_FINITE | {s1_q.sign, 31'b0});
      of_calc  = 1'b1;
      uf_calc  = 1'b0;
      nx_calc  = 1'b1;
    end
  end

  // Output registers only move when stage 2 loads a valid beat, so stalls hold them.
  always_comb begin
    load2 = ~v2_q | Ready_SI;
    load1 = ~v1_q | load2;
    v1_d  = load1 ? Valid_SI : v1_q;
    s1_d  = (load1 & Valid_SI) ? s1_calc : s1_q;
    v2_d  = load2 ? v1_q : v2_q;
    res_d = (load2 & v1_q) ? res_calc : res_q;
    of_d  = (load2 & v1_q) ? of_calc  : of_q;
    uf_d  = (load2 & v1_q) ? uf_calc  : uf_q;
    nx_d  = (load2 & v1_q) ? nx_calc  : nx_q;
    nv_d  = (load2 & v1_q) ? nv_calc  : nv_q;
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      v1_q  <= 1'b0;
      s1_q  <= '0;
      v2_q  <= 1'b0;
      res_q <= '0;
      of_q  <= 1'b0;
      uf_q  <= 1'b0;
      nx_q  <= 1'b0;
      nv_q  <= 1'b0;
    end else begin
      v1_q  <= v1_d;
      s1_q  <= s1_d;
      v2_q  <= v2_d;
      res_q <= res_d;
      of_q  <= of_d;
      uf_q  <= uf_d;
      nx_q  <= nx_d;
      nv_q  <= nv_d;
    end
  end

  assign Ready_SO = load1;
  assign Valid_SO = v2_q;
  assign Res_DO   = res_q;
  assign OF_SO    = of_q;
  assign UF_SO    = uf_q;
  assign NX_SO    = nx_q;
  assign NV_SO    = nv_q;

endmodule

// File: tb/tb_fmac_round_pack.sv
// Directed bench for fmac_round_pack: hand-computed vectors per feature, plus
// streaming with backpressure and a mid-stream reset.
module tb_fmac_round_pack;

  logic        Clk_CI = 1'b0;
  logic        Rst_RI;
  logic        Valid_SI, Ready_SO, Sign_DI, Sticky_SI;
  logic [9:0]  Exp_DI;
  logic [47:0] Mant_DI;
  logic [1:0]  RM_SI;
  logic        NaN_SI, Inf_SI, Invalid_SI;
  logic        Valid_SO, Ready_SI;
  logic [31:0] Res_DO;
  logic        OF_SO, UF_SO, NX_SO, NV_SO;

  int checks = 0;
  int errors = 0;

  // Flags are packed as {OF, UF, NX, NV}.
  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] mant;
    logic        sticky;
    logic [1:0]  rm;
    logic        nan;
    logic        inf;
    logic        inv;
    logic [31:0] res;
    logic [3:0]  flags;
  } vec_t;

  always #5 Clk_CI = ~Clk_CI;

  fmac_round_pack dut (
    .Clk_CI     (Clk_CI),
    .Rst_RI     (Rst_RI),
    .Valid_SI   (Valid_SI),
    .Ready_SO   (Ready_SO),
    .Sign_DI    (Sign_DI),
    .Exp_DI     (Exp_DI),
    .Mant_DI    (Mant_DI),
    .Sticky_SI  (Sticky_SI),
    .RM_SI      (RM_SI),
    .NaN_SI     (NaN_SI),
    .Inf_SI     (Inf_SI),
    .Invalid_SI (Invalid_SI),
    .Valid_SO   (Valid_SO),
    .Ready_SI   (Ready_SI),
    .Res_DO     (Res_DO),
    .OF_SO      (OF_SO),
    .UF_SO      (UF_SO),
    .NX_SO      (NX_SO),
    .NV_SO      (NV_SO)
  );

  // Sends one beat into an empty pipeline and returns the result and the number
  // of clock edges from accept to Valid_SO (-1 if it never appears).
  task automatic run_beat(input vec_t v, output logic [31:0] res,
                          output logic [3:0] flags, output int lat);
    int edges;
    bit done;
    @(negedge Clk_CI);
    Sign_DI = v.sign; Exp_DI = v.exp; Mant_DI = v.mant; Sticky_SI = v.sticky;
    RM_SI = v.rm; NaN_SI = v.nan; Inf_SI = v.inf; Invalid_SI = v.inv;
    Valid_SI = 1'b1; Ready_SI = 1'b1;
    @(posedge Clk_CI); #1;
    Valid_SI = 1'b0;
    edges = 1; done = 1'b0; lat = -1;
    while (!done && edges <= 8) begin
      if (Valid_SO) begin
        lat = edges;
        done = 1'b1;
      end else begin
        @(posedge Clk_CI); #1;
        edges++;
      end
    end
    res   = Res_DO;
    flags = {OF_SO, UF_SO, NX_SO, NV_SO};
    @(posedge Clk_CI); #1;
  endtask

  task automatic test_reset();
    Rst_RI = 1'b0; Valid_SI = 1'b0; Ready_SI = 1'b0;
    #2 Rst_RI = 1'b1;
    #1;
    checks++;
    if ({Valid_SO, Res_DO, OF_SO, UF_SO, NX_SO, NV_SO} !== 37'b0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b res=%h flags=%b%b%b%b want all 0",
               Valid_SO, Res_DO, OF_SO, UF_SO, NX_SO, NV_SO);
    end
    repeat (2) @(posedge Clk_CI);
    @(negedge Clk_CI);
    Rst_RI = 1'b0;
    #1;
    checks++;
    if (Valid_SO !== 1'b0 || Ready_SO !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got valid=%b ready=%b want valid=0 ready=1", Valid_SO, Ready_SO);
    end
  endtask

  task automatic test_normal();
    vec_t v[5];
    logic [31:0] r; logic [3:0] f; int lat;
    v = '{
      '{1'b0, 10'd127, 48'h400000000000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h3F800000, 4'b0000},
      '{1'b0, 10'd126, 48'h800000800000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h3F800000, 4'b0010},
      '{1'b0, 10'd126, 48'h800000800000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h3F800001, 4'b0010},
      '{1'b0, 10'd126, 48'hFFFFFFC00000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h40000000, 4'b0010},
      '{1'b0, 10'd126, 48'hFFFFFFC00000, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 32'h3FFFFFFF, 4'b0010}
    };
    for (int i = 0; i < 5; i++) begin
      run_beat(v[i], r, f, lat);
      checks++;
      if (r !== v[i].res) begin
        errors++;
        $display("FAIL normal[%0d] res got %h want %h", i, r, v[i].res);
      end
      checks++;
      if (f !== v[i].flags) begin
        errors++;
        $display("FAIL normal[%0d] flags got %b want %b", i, f, v[i].flags);
      end
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL normal[%0d] latency got %0d want 2", i, lat);
      end
    end
  endtask

  task automatic test_overflow();
    vec_t v[6];
    logic [31:0] r; logic [3:0] f; int lat;
    v = '{
      '{1'b0, 10'd300, 48'h400000000000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h7F800000, 4'b1010},
      '{1'b0, 10'd300, 48'h400000000000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 32'h7F7FFFFF, 4'b1010},
      '{1'b1, 10'd300, 48'h400000000000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 32'hFF7FFFFF, 4'b1010},
      '{1'b1, 10'd300, 48'h400000000000, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 32'hFF800000, 4'b1010},
      '{1'b0, 10'd253, 48'hFFFFFFC00000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h7F800000, 4'b1010},
      '{1'b0, 10'd253, 48'hFFFFFF000000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h7F7FFFFF, 4'b0000}
    };
    for (int i = 0; i < 6; i++) begin
      run_beat(v[i], r, f, lat);
      checks++;
      if (r !== v[i].res || f !== v[i].flags || lat !== 2) begin
        errors++;
        $display("FAIL overflow[%0d] got res=%h flags=%b lat=%0d want res=%h flags=%b lat=2",
                 i, r, f, lat, v[i].res, v[i].flags);
      end
    end
  endtask

  task automatic test_subnormal();
    vec_t v[7];
    logic [31:0] r; logic [3:0] f; int lat;
    v = '{
      '{1'b0, 10'h3F6, 48'h400000000000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 32'h00001000, 4'b0000},
      '{1'b0, 10'h3F6, 48'h400000000000, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 32'h00001000, 4'b0110},
      '{1'b0, 10'h3F6, 48'h400000000001, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 32'h00001000, 4'b0110},
      '{1'b0, 10'd0,   48'h400000000000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h00400000, 4'b0000},
      '{1'b0, 10'd0,   48'h7FFFFF800000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h00800000, 4'b0110},
      '{1'b0, 10'h338, 48'h400000000000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'b0110},
      '{1'b0, 10'h338, 48'h400000000000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h00000001, 4'b0110}
    };
    for (int i = 0; i < 7; i++) begin
      run_beat(v[i], r, f, lat);
      checks++;
      if (r !== v[i].res || f !== v[i].flags || lat !== 2) begin
        errors++;
        $display("FAIL subnormal[%0d] got res=%h flags=%b lat=%0d want res=%h flags=%b lat=2",
                 i, r, f, lat, v[i].res, v[i].flags);
      end
    end
  endtask

  task automatic test_specials();
    vec_t v[6];
    logic [31:0] r; logic [3:0] f; int lat;
    v = '{
      '{1'b0, 10'd127, 48'h400000000000, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 32'h7FC00000, 4'b0001},
      '{1'b1, 10'd127, 48'h400000000000, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 32'h7FC00000, 4'b0000},
      '{1'b1, 10'd127, 48'h400000000000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 32'hFF800000, 4'b0000},
      '{1'b0, 10'd300, 48'h400000000000, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 32'h7F800000, 4'b0000},
      '{1'b1, 10'd127, 48'h000000000000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h80000000, 4'b0000},
      '{1'b0, 10'd127, 48'h000000000000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'b0000}
    };
    for (int i = 0; i < 6; i++) begin
      run_beat(v[i], r, f, lat);
      checks++;
      if (r !== v[i].res || f !== v[i].flags || lat !== 2) begin
        errors++;
        $display("FAIL specials[%0d] got res=%h flags=%b lat=%0d want res=%h flags=%b lat=2",
                 i, r, f, lat, v[i].res, v[i].flags);
      end
    end
  endtask

  // Beat k carries 1.k-style value with biased exponent 100+k and fraction k, so
  // its packed result is {0, 100+k, k} with no rounding.
  task automatic test_back_to_back(input bit random_ready);
    int sent, got, cyc;
    bit stalled;
    logic [31:0] held, want;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
    Sign_DI = 1'b0; Sticky_SI = 1'b0; RM_SI = 2'd0;
    NaN_SI = 1'b0; Inf_SI = 1'b0; Invalid_SI = 1'b0;
    while ((sent < 10 || got < 10) && cyc < 200) begin
      @(negedge Clk_CI);
      Ready_SI = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent < 10) begin
        Valid_SI = 1'b1;
        Exp_DI   = 10'(100 + sent);
        Mant_DI  = 48'h400000000000 | (48'(sent) << 23);
      end else begin
        Valid_SI = 1'b0;
      end
      #1;
      if (stalled) begin
        checks++;
        if (Res_DO !== held) begin
          errors++;
          $display("FAIL stall_hold got %h want %h", Res_DO, held);
        end
      end
      if (!random_ready && sent < 10) begin
        checks++;
        if (Ready_SO !== 1'b1) begin
          errors++;
          $display("FAIL full_rate_ready cycle %0d got %b want 1", cyc, Ready_SO);
        end
      end
      if (Valid_SO && Ready_SI) begin
        want = {1'b0, 8'(100 + got), 23'(got)};
        checks++;
        if (Res_DO !== want || NX_SO !== 1'b0) begin
          errors++;
          $display("FAIL stream_beat[%0d] got %h nx=%b want %h nx=0", got, Res_DO, NX_SO, want);
        end
        got++;
      end
      stalled = Valid_SO & ~Ready_SI;
      held    = Res_DO;
      if (Valid_SI && Ready_SO) sent++;
      cyc++;
    end
    @(negedge Clk_CI);
    Valid_SI = 1'b0;
    Ready_SI = 1'b1;
    checks++;
    if (got !== 10) begin
      errors++;
      $display("FAIL stream_count got %0d want 10", got);
    end
    if (!random_ready) begin
      checks++;
      if (cyc !== 12) begin
        errors++;
        $display("FAIL full_rate_cycles got %0d want 12", cyc);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk_CI); #1;
      checks++;
      if (Valid_SO !== 1'b0) begin
        errors++;
        $display("FAIL stream_duplicate idle %0d got valid=%b want 0", i, Valid_SO);
      end
    end
  endtask

  task automatic test_reset_midstream();
    vec_t v;
    logic [31:0] r; logic [3:0] f; int lat;
    @(negedge Clk_CI);
    Ready_SI = 1'b0; Valid_SI = 1'b1;
    Sign_DI = 1'b0; Exp_DI = 10'd127; Mant_DI = 48'h400000000000; Sticky_SI = 1'b0;
    RM_SI = 2'd0; NaN_SI = 1'b0; Inf_SI = 1'b0; Invalid_SI = 1'b0;
    repeat (3) @(negedge Clk_CI);
    #1;
    checks++;
    if (Valid_SO !== 1'b1 || Ready_SO !== 1'b0) begin
      errors++;
      $display("FAIL fill_before_reset got valid=%b ready=%b want valid=1 ready=0", Valid_SO, Ready_SO);
    end
    #1 Rst_RI = 1'b1;
    #1;
    checks++;
    if (Valid_SO !== 1'b0 || Res_DO !== 32'h0) begin
      errors++;
      $display("FAIL reset_async got valid=%b res=%h want valid=0 res=0", Valid_SO, Res_DO);
    end
    Valid_SI = 1'b0;
    @(negedge Clk_CI);
    Rst_RI = 1'b0;
    Ready_SI = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk_CI); #1;
      checks++;
      if (Valid_SO !== 1'b0) begin
        errors++;
        $display("FAIL reset_stale cycle %0d got valid=%b want 0", i, Valid_SO);
      end
    end
    v = '{1'b1, 10'd128, 48'h400000000000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'hC0000000, 4'b0000};
    run_beat(v, r, f, lat);
    checks++;
    if (r !== v.res || f !== v.flags || lat !== 2) begin
      errors++;
      $display("FAIL after_reset got res=%h flags=%b lat=%0d want res=%h flags=0000 lat=2",
               r, f, lat, v.res);
    end
  endtask

  initial begin
    Valid_SI = 1'b0; Ready_SI = 1'b0; Sign_DI = 1'b0; Exp_DI = '0; Mant_DI = '0;
    Sticky_SI = 1'b0; RM_SI = '0; NaN_SI = 1'b0; Inf_SI = 1'b0; Invalid_SI = 1'b0;
    test_reset();
    test_normal();
    test_overflow();
    test_subnormal();
    test_specials();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
